mul_arbiter: RTL



---
 rtl/mul_arbiter_if.sv | 28 ++
 rtl/mul_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter_if.sv
// Request, response and multiplier-side signals of mul_arbiter.
// The arbiter uses the slave modport; requesters and the multiplier sit on the master side.
interface mul_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [2*WIDTH-1:0]    mul_p;
  logic [NREQ-1:0]       resp_valid;
  logic [2*WIDTH-1:0]    resp_data;
  logic [NREQ-1:0]       resp_ready;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, resp_ready,
    output req_ready, mul_a, mul_b, resp_valid, resp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, resp_ready,
    input  req_ready, mul_a, mul_b, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin sequencer sharing one combinational signed multiplier among NREQ requesters.
// Define MUL_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module mul_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  mul_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic [WIDTH-1:0]  mul_a_q, mul_a_d;
  logic [WIDTH-1:0]  mul_b_q, mul_b_d;
  logic [PW-1:0]     resp_data_q, resp_data_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   req_ready_s;
  logic              win_found_s;
  logic [PTR_W-1:0]  win_idx_s;

`ifdef MUL_ARB_FIXED_PRIO_EN
`else
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

  // Winner search: first asserted req_valid at or above the start index, wrapping at NREQ-1.
  always_comb begin
    logic [PTR_W:0]   sum_w;
    logic [PTR_W:0]   cand_w;
    logic [PTR_W-1:0] cand;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    sum_w       = '0;
    cand_w      = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
      sum_w = (PTR_W+1)'(k);
`else
      sum_w = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
`endif
      if (sum_w >= (PTR_W+1)'(NREQ)) begin
        cand_w = sum_w - (PTR_W+1)'(NREQ);
      end else begin
        cand_w = sum_w;
      end
      cand = cand_w[PTR_W-1:0];
      if (!win_found_s && bus.req_valid[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Accept strobe is only offered in IDLE, and never while reset is held.
  always_comb begin
    req_ready_s = '0;
    if ((state_q == IDLE) && !rst && win_found_s) begin
      req_ready_s[win_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    busy_d       = busy_q;
`ifdef MUL_ARB_FIXED_PRIO_EN
`else
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          grant_d = win_idx_s;
          mul_a_d = bus.req_a[int'(win_idx_s)*WIDTH +: WIDTH];
          mul_b_d = bus.req_b[int'(win_idx_s)*WIDTH +: WIDTH];
          busy_d  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // The multiplier answer is already settled from the registered operands.
        resp_data_d           = bus.mul_p;
        resp_valid_d          = '0;
        resp_valid_d[grant_q] = 1'b1;
        state_d               = RESP;
      end
      RESP: begin
        if (bus.resp_ready[grant_q]) begin
          resp_valid_d = '0;
          busy_d       = 1'b0;
          state_d      = IDLE;
`ifdef MUL_ARB_FIXED_PRIO_EN
`else
          if (grant_q == PTR_W'(NREQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_q + PTR_W'(1);
          end
`endif
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        resp_valid_d = '0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

`ifdef MUL_ARB_FIXED_PRIO_EN
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign bus.req_ready  = req_ready_s;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = busy_q;
endmodule
